// File: rtl/mcu_bus_bridge.sv
// mcu_bus_bridge: MCU asynchronous external-memory bus to internal peripheral bus.
// Strobes are synchronised with 2-flop chains, then a six-state FSM issues exactly
// one single-cycle cs/we access per MCU strobe and returns read data to the pads.
// Optional feature macro: BRIDGE_ERR_CNT_EN builds the saturating error counter;
// without it err_count is tied to zero.
module mcu_bus_bridge #(
    parameter int ADDR_W   = 12,
    parameter int N_PERIPH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mcu_ncs,
    input  logic                  mcu_nwe,
    input  logic                  mcu_nrd,
    input  logic [ADDR_W-1:0]     mcu_addr,
    input  logic [7:0]            mcu_d_in,
    output logic [7:0]            mcu_d_out,
    output logic                  mcu_d_oe,
    output logic [N_PERIPH-1:0]   cs,
    output logic                  we,
    output logic [7:0]            buffer_address,
    output logic [7:0]            buffer_data,
    input  logic [8*N_PERIPH-1:0] periph_data,
    output logic [7:0]            err_count
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_REL, RD_REQ, RD_CAP, RD_HOLD
    } state_t;

    state_t                state_q;
    logic [2:0]            sync_meta_q;
    logic [2:0]            sync_s_q;
    logic [N_PERIPH-1:0]   cs_q;
    logic                  we_q;
    logic [7:0]            buffer_address_q;
    logic [7:0]            buffer_data_q;
    logic [7:0]            mcu_d_out_q;
    logic                  mcu_d_oe_q;
    logic [1:0]            sel_q;
    logic                  mapped_q;

    logic ncs_s, nwe_s, nrd_s;
    logic wr_go, rd_go, wr_rel, rd_rel, mapped_now;

    function automatic logic [N_PERIPH-1:0] onehot(input logic [1:0] s);
        logic [N_PERIPH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Two-flop synchronisers for the three strobes; idle (high) out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 3'b111;
            sync_s_q    <= 3'b111;
        end else begin
            sync_meta_q <= {mcu_ncs, mcu_nwe, mcu_nrd};
            sync_s_q    <= sync_meta_q;
        end
    end

    assign ncs_s      = sync_s_q[2];
    assign nwe_s      = sync_s_q[1];
    assign nrd_s      = sync_s_q[0];
    assign wr_go      = !ncs_s && !nwe_s;
    assign rd_go      = !ncs_s && !nrd_s;
    assign wr_rel     = nwe_s || ncs_s;
    assign rd_rel     = nrd_s || ncs_s;
    assign mapped_now = (mcu_addr[ADDR_W-1:10] == '0);

    // Transaction FSM; every bus and pad output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cs_q             <= '0;
            we_q             <= 1'b0;
            buffer_address_q <= 8'h00;
            buffer_data_q    <= 8'h00;
            mcu_d_out_q      <= 8'h00;
            mcu_d_oe_q       <= 1'b0;
            sel_q            <= 2'b00;
            mapped_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cs_q <= '0;
                    we_q <= 1'b0;
                    // Write wins when both strobes are low
                    if (wr_go) begin
                        state_q          <= WR;
                        buffer_address_q <= mcu_addr[7:0];
                        buffer_data_q    <= mcu_d_in;
                        sel_q            <= mcu_addr[9:8];
                        mapped_q         <= mapped_now;
                        cs_q             <= mapped_now ? onehot(mcu_addr[9:8]) : '0;
                        we_q             <= 1'b1;
                    end else if (rd_go) begin
                        state_q          <= RD_REQ;
                        buffer_address_q <= mcu_addr[7:0];
                        sel_q            <= mcu_addr[9:8];
                        mapped_q         <= mapped_now;
                        cs_q             <= mapped_now ? onehot(mcu_addr[9:8]) : '0;
                    end
                end
                WR: begin
                    cs_q    <= '0;
                    we_q    <= 1'b0;
                    state_q <= WR_REL;
                end
                WR_REL: begin
                    if (wr_rel) state_q <= IDLE;
                end
                RD_REQ: begin
                    cs_q    <= '0;
                    state_q <= RD_CAP;
                end
                RD_CAP: begin
                    // Peripheral drives data_out the cycle after its cs pulse
                    mcu_d_out_q <= mapped_q ? periph_data[{sel_q, 3'b000} +: 8] : 8'h00;
                    mcu_d_oe_q  <= 1'b1;
                    state_q     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_rel) begin
                        mcu_d_oe_q  <= 1'b0;
                        mcu_d_out_q <= 8'h00;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cs_q    <= '0;
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BRIDGE_ERR_CNT_EN
    logic       err_flag_q;
    logic [7:0] err_count_q;

    // Flag an access as unmapped or aborted; count it once when it returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag_q  <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE:           if (wr_go || rd_go) err_flag_q <= !mapped_now;
                WR:             if (wr_rel) err_flag_q <= 1'b1;
                RD_REQ, RD_CAP: if (rd_rel) err_flag_q <= 1'b1;
                WR_REL: begin
                    if (wr_rel && err_flag_q && err_count_q != 8'hFF)
                        err_count_q <= err_count_q + 8'h01;
                end
                RD_HOLD: begin
                    if (rd_rel && err_flag_q && err_count_q != 8'hFF)
                        err_count_q <= err_count_q + 8'h01;
                end
                default: err_flag_q <= 1'b0;
            endcase
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

    assign cs             = cs_q;
    assign we             = we_q;
    assign buffer_address = buffer_address_q;
    assign buffer_data    = buffer_data_q;
    assign mcu_d_out      = mcu_d_out_q;
    assign mcu_d_oe       = mcu_d_oe_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Testbench for mcu_bus_bridge: directed plan items followed by random MCU
// accesses, scored against a transaction-level model of the register map.
module tb_mcu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mcu_ncs = 1'b1;
    logic        mcu_nwe = 1'b1;
    logic        mcu_nrd = 1'b1;
    logic [11:0] mcu_addr = 12'h000;
    logic [7:0]  mcu_d_in = 8'h00;
    logic [7:0]  mcu_d_out;
    logic        mcu_d_oe;
    logic [3:0]  cs;
    logic        we;
    logic [7:0]  buffer_address;
    logic [7:0]  buffer_data;
    logic [31:0] periph_data;
    logic [7:0]  err_count;

    mcu_bus_bridge #(.ADDR_W(12), .N_PERIPH(4)) dut (
        .clk(clk), .rst(rst),
        .mcu_ncs(mcu_ncs), .mcu_nwe(mcu_nwe), .mcu_nrd(mcu_nrd),
        .mcu_addr(mcu_addr), .mcu_d_in(mcu_d_in),
        .mcu_d_out(mcu_d_out), .mcu_d_oe(mcu_d_oe),
        .cs(cs), .we(we),
        .buffer_address(buffer_address), .buffer_data(buffer_data),
        .periph_data(periph_data), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Four simple peripheral register blocks obeying the cs/we contract
    logic [7:0] pmem [4][256];
    logic [7:0] pdata [4];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                pdata[k] <= 8'h00;
                for (int a = 0; a < 256; a++) pmem[k][a] <= 8'h00;
            end else if (cs[k]) begin
                if (we) pmem[k][buffer_address] <= buffer_data;
                else    pdata[k] <= pmem[k][buffer_address];
            end
        end
    end
    assign periph_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    // Bus monitor: records every cs pulse and pad-enable activity
    typedef struct packed {
        logic [3:0] cs;
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
    } pulse_t;
    pulse_t     pulses[$];
    int         b2b = 0;
    int         oe_cycles = 0;
    int         cyc = 0;
    int         cs_cyc = 0;
    int         oe_rise_cyc = 0;
    logic [3:0] prev_cs = 4'h0;
    logic       prev_oe = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_cs = 4'h0;
            prev_oe = 1'b0;
        end else begin
            if (cs != 4'h0) begin
                pulses.push_back({cs, we, buffer_address, buffer_data});
                if (prev_cs != 4'h0) b2b++;
                cs_cyc = cyc;
            end
            if (mcu_d_oe) begin
                oe_cycles++;
                if (!prev_oe) oe_rise_cyc = cyc;
            end
            prev_cs = cs;
            prev_oe = mcu_d_oe;
        end
    end

    // Reference model: register contents per slot and expected error count
    logic [7:0] exp_mem [4][256];
    int         exp_err = 0;

    function automatic logic is_mapped(input logic [11:0] a);
        return a[11:10] == 2'b00;
    endfunction

    function automatic logic [3:0] slot_bit(input logic [11:0] a);
        logic [3:0] v;
        v = 4'h0;
        v[a[9:8]] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] err_exp();
`ifdef BRIDGE_ERR_CNT_EN
        return 32'(exp_err);
`else
        return 32'h0;
`endif
    endfunction

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 256; a++) exp_mem[k][a] = 8'h00;
        exp_err = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int low);
        pulse_t p;
        pulses.delete();
        b2b = 0;
        @(negedge clk);
        mcu_addr = a; mcu_d_in = d; mcu_ncs = 1'b0; mcu_nwe = 1'b0;
        repeat (low) @(negedge clk);
        mcu_ncs = 1'b1; mcu_nwe = 1'b1;
        repeat (6) @(negedge clk);
        if (is_mapped(a)) exp_mem[a[9:8]][a[7:0]] = d;
        else bump_err();
        $display("WR  addr=%03h data=%02h low=%0d pulses=%0d", a, d, low, pulses.size());
        check("wr_pulses", 32'(pulses.size()), is_mapped(a) ? 32'd1 : 32'd0);
        if (pulses.size() == 1) begin
            p = pulses[0];
            check("wr_cs", 32'(p.cs), 32'(slot_bit(a)));
            check("wr_we", 32'(p.we), 32'd1);
            check("wr_addr", 32'(p.a), 32'(a[7:0]));
            check("wr_data", 32'(p.d), 32'(d));
        end
        check("wr_b2b", 32'(b2b), 32'd0);
        check("wr_err", 32'(err_count), err_exp());
    endtask

    task automatic do_read(input logic [11:0] a, input int low);
        logic [7:0] got_d;
        logic       got_oe;
        logic [7:0] exp_d;
        pulse_t     p;
        pulses.delete();
        b2b = 0;
        exp_d = is_mapped(a) ? exp_mem[a[9:8]][a[7:0]] : 8'h00;
        @(negedge clk);
        mcu_addr = a; mcu_ncs = 1'b0; mcu_nrd = 1'b0;
        repeat (low - 1) @(negedge clk);
        got_d = mcu_d_out;
        got_oe = mcu_d_oe;
        @(negedge clk);
        mcu_ncs = 1'b1; mcu_nrd = 1'b1;
        repeat (6) @(negedge clk);
        if (!is_mapped(a)) bump_err();
        $display("RD  addr=%03h data=%02h exp=%02h low=%0d pulses=%0d", a, got_d, exp_d, low, pulses.size());
        check("rd_oe", 32'(got_oe), 32'd1);
        check("rd_data", 32'(got_d), 32'(exp_d));
        check("rd_pulses", 32'(pulses.size()), is_mapped(a) ? 32'd1 : 32'd0);
        if (pulses.size() == 1) begin
            p = pulses[0];
            check("rd_cs", 32'(p.cs), 32'(slot_bit(a)));
            check("rd_we", 32'(p.we), 32'd0);
            check("rd_addr", 32'(p.a), 32'(a[7:0]));
            check("rd_latency", 32'(oe_rise_cyc - cs_cyc), 32'd2);
        end
        check("rd_rel_oe", 32'(mcu_d_oe), 32'd0);
        check("rd_rel_dout", 32'(mcu_d_out), 32'd0);
        check("rd_err", 32'(err_count), err_exp());
    endtask

    initial begin
        int n;
        logic [11:0] ra;
        logic [7:0]  rd;
        clear_model();
        repeat (3) @(negedge clk);
        // Reset values
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_baddr", 32'(buffer_address), 32'd0);
        check("rst_bdata", 32'(buffer_data), 32'd0);
        check("rst_dout", 32'(mcu_d_out), 32'd0);
        check("rst_oe", 32'(mcu_d_oe), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed plan items
        do_write(12'h104, 8'hA5, 6);
        do_write(12'h208, 8'h3C, 6);
        do_read(12'h208, 10);
        do_read(12'h400, 9);

        // Both strobes low: write wins, single pulse
        pulses.delete();
        @(negedge clk);
        mcu_addr = 12'h00C; mcu_d_in = 8'h11;
        mcu_ncs = 1'b0; mcu_nwe = 1'b0; mcu_nrd = 1'b0;
        repeat (6) @(negedge clk);
        mcu_ncs = 1'b1; mcu_nwe = 1'b1; mcu_nrd = 1'b1;
        repeat (6) @(negedge clk);
        exp_mem[0][8'h0C] = 8'h11;
        $display("WRD addr=00c data=11 pulses=%0d", pulses.size());
        check("both_pulses", 32'(pulses.size()), 32'd1);
        if (pulses.size() == 1) begin
            check("both_cs", 32'(pulses[0].cs), 32'h1);
            check("both_we", 32'(pulses[0].we), 32'd1);
        end
        do_read(12'h00C, 8);

        // Read strobe released while the request is still in flight
        pulses.delete();
        oe_cycles = 0;
        @(negedge clk);
        mcu_addr = 12'h104; mcu_ncs = 1'b0; mcu_nrd = 1'b0;
        repeat (2) @(negedge clk);
        mcu_ncs = 1'b1; mcu_nrd = 1'b1;
        repeat (8) @(negedge clk);
        bump_err();
        $display("ABT addr=104 pulses=%0d oe_cycles=%0d", pulses.size(), oe_cycles);
        check("abort_pulses", 32'(pulses.size()), 32'd1);
        check("abort_oe_le1", 32'(oe_cycles <= 1), 32'd1);
        check("abort_err", 32'(err_count), err_exp());
        do_write(12'h30F, 8'h5A, 5);
        do_read(12'h30F, 9);

        // Asynchronous reset during RD_HOLD, strobe kept low across release
        pulses.delete();
        @(negedge clk);
        mcu_addr = 12'h104; mcu_ncs = 1'b0; mcu_nrd = 1'b0;
        n = 0;
        while (!mcu_d_oe && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", 32'(mcu_d_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        $display("RST during hold oe=%0d cs=%0h dout=%02h", mcu_d_oe, cs, mcu_d_out);
        check("arst_oe", 32'(mcu_d_oe), 32'd0);
        check("arst_cs", 32'(cs), 32'd0);
        check("arst_dout", 32'(mcu_d_out), 32'd0);
        check("arst_err", 32'(err_count), 32'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses.delete();
        repeat (8) @(negedge clk);
        $display("RD  after reset pulses=%0d oe=%0d dout=%02h", pulses.size(), mcu_d_oe, mcu_d_out);
        check("post_rst_pulses", 32'(pulses.size()), 32'd1);
        check("post_rst_oe", 32'(mcu_d_oe), 32'd1);
        check("post_rst_dout", 32'(mcu_d_out), 32'h00);
        mcu_ncs = 1'b1; mcu_nrd = 1'b1;
        repeat (6) @(negedge clk);

        // Random accesses over a small address window so reads hit written data
        for (int i = 0; i < 30; i++) begin
            ra = 12'($urandom_range(0, 4095));
            ra[7:3] = 5'h00;
            if ($urandom_range(0, 3) != 0) ra[11:10] = 2'b00;
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(ra, rd, int'($urandom_range(3, 8)));
            else do_read(ra, int'($urandom_range(8, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcu_bus_bridge.md
# mcu_bus_bridge

Bridge from the MCU external-memory bus (asynchronous active-low strobes) to the FPGA's internal peripheral bus. It synchronises MCU strobes into the FPGA clock domain and decodes the peripheral select. It issues single-cycle `cs`/`we` transactions with an 8-bit local address and write data to up to four peripheral register blocks. It returns the selected peripheral's read data to the MCU data pads. It sits between the top-level pad ring and every memory-mapped peripheral.

## Interface
Parameters:
- `ADDR_W`, 12, MCU address width. Bits `[11:10]` must be 0 for a mapped access. Bits `[9:8]` select the peripheral. Bits `[7:0]` form the local address.
- `N_PERIPH`, 4, number of peripheral slots, fixed at 4 for this block.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `mcu_ncs`  in  1  MCU chip select, active low, asynchronous to `clk`
- `mcu_nwe`  in  1  MCU write strobe, active low, asynchronous
- `mcu_nrd`  in  1  MCU read strobe, active low, asynchronous
- `mcu_addr`  in  ADDR_W  MCU address
- `mcu_d_in`  in  8  MCU write data, from the pad
- `mcu_d_out`  out  8  read data to the pad
- `mcu_d_oe`  out  1  pad output enable
- `cs`  out  N_PERIPH  one-hot peripheral select
- `we`  out  1  write enable, qualified by `cs`
- `buffer_address`  out  8  local register address
- `buffer_data`  out  8  write data
- `periph_data`  in  8*N_PERIPH  concatenated peripheral `data_out`; slot k occupies `[8k+7:8k]`
- `err_count`  out  8  unmapped/abort event counter (see Configuration)

## Operation
- `mcu_ncs`, `mcu_nwe` and `mcu_nrd` each pass through a 2-flop synchroniser. The synchronised signals are `ncs_s`, `nwe_s` and `nrd_s`. Synchroniser flops reset to 1.
- Address and data are sampled directly from the pins on the detect edge. The MCU timing guarantees they are stable for the full strobe.
- The FSM has six states: IDLE, WR, WR_REL, RD_REQ, RD_CAP, RD_HOLD.
- Transitions out of IDLE:
  - `ncs_s=0 & nwe_s=0` → WR. On this edge, latch `buffer_address=mcu_addr[7:0]`, `buffer_data=mcu_d_in` and `sel=mcu_addr[9:8]`, and register `mapped = (mcu_addr[11:10]==0)`.
  - Otherwise, `ncs_s=0 & nrd_s=0` → RD_REQ, with the same address latch. `buffer_data` is unchanged.
  - If `nwe_s` and `nrd_s` are both low, the write wins.
- Transitions out of the other states:
  - WR: `cs=onehot(sel)` if mapped, else 0; `we=1`. Lasts exactly one cycle → WR_REL.
  - WR_REL: `cs=0`, `we=0`. Stay until `nwe_s=1 | ncs_s=1` → IDLE.
  - RD_REQ: `cs=onehot(sel)` if mapped; `we=0`. Lasts one cycle → RD_CAP.
  - RD_CAP: `cs=0`. On the exit edge, `mcu_d_out <= mapped ? periph_data[sel] : 8'h00` → RD_HOLD.
  - RD_HOLD: `mcu_d_oe=1`, `mcu_d_out` held. Stay while `nrd_s=0 & ncs_s=0`. On release → IDLE; on that edge `mcu_d_oe<=0` and `mcu_d_out<=0`.
- Strobe released during WR, RD_REQ or RD_CAP: the internal transaction completes. RD_HOLD then exits on its first cycle. This counts as an abort.
- `cs` is never active in two consecutive cycles. Exactly one peripheral access occurs per MCU strobe.

## Timing
- Reset values: `cs=0`, `we=0`, `buffer_address=0`, `buffer_data=0`, `mcu_d_out=0`, `mcu_d_oe=0`, `err_count=0`, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-transaction aborts immediately with no further `cs` pulse.
- After reset release, a strobe that is already low is treated as a new access.
- All outputs are registered.
- Write: pin fall → synchronised detect takes 2–3 cycles → `cs`/`we` high 1 cycle later, for 1 cycle.
- Read: detect edge → RD_REQ (+1) → RD_CAP (+2) → `mcu_d_oe=1` with valid data at +3.
- MCU requirement: `nrd` low for at least 7 `clk` cycles before the MCU samples data. Minimum strobe-high time between accesses is 3 cycles.
- The peripheral contract is that `data_out` is valid in the cycle after `cs=1, we=0`.

## Configuration
- `BRIDGE_ERR_CNT_EN` defined: `err_count` is an 8-bit counter.
  - It increments once per unmapped access and once per aborted transaction; an access that is both counts once.
  - It saturates at 8'hFF and is cleared only by `rst`.
- Not defined: `err_count` is tied to 8'h00 and no counter logic is built.

## Test plan
- Write `addr=12'h104`, `data=8'hA5`, `nwe` low for 6 cycles → one-cycle `cs=4'b0010`, `we=1`, `buffer_address=8'h04`, `buffer_data=8'hA5`. `cs` stays 0 until the strobe rises.
- Read `addr=12'h208`, slot-2 `periph_data=8'h3C` after `cs` → `mcu_d_oe=1`, `mcu_d_out=8'h3C` 3 cycles after detect, held until `nrd` rises. Then `mcu_d_oe=0` and `mcu_d_out=0`.
- Unmapped read `addr=12'h400` → `cs` stays 0, `mcu_d_out=8'h00`, `err_count` increments to 1 (macro on).
- `nwe` and `nrd` both low at `addr=12'h00C`, `data=8'h11` → write to slot 0 only, no read `cs` pulse.
- `nrd` released during RD_REQ → single `cs` pulse, `mcu_d_oe` high for at most 1 cycle, `err_count` +1. A subsequent write succeeds normally.
- `rst` asserted during RD_HOLD → `mcu_d_oe=0` and `cs=0` immediately (asynchronously), FSM returns to IDLE.
